// File: rtl/apb_ctrl_pkg.sv
// ============================================================================
// Module      : apb_ctrl_pkg
// Description : Shared types and sizing helpers for the APB master arbiter.
//               state_e     - transfer sequencer states
//               strb_width  - byte-strobe width for a data width
//               sidx_width  - index width for a count (minimum 1 bit)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  function automatic int strb_width(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int sidx_width(input int s);
    return (s <= 1) ? 1 : $clog2(s);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
// ============================================================================
// Module      : apb_rr_arbiter
// Description : Round-robin arbiter. Searches upward from the slot after the
//               last winner; the pointer advances to the winner on update.
//               Reset pointer is N-1 so requester 0 has first priority.
// Ports       : clk, reset_n (sync, active-low)
//               req    [N]  request vector
//               update      commit the current grant to the pointer
//               grant  [N]  one-hot grant (zero when no request)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_rr_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = sidx_width(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] grant
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= IDX_W'(N - 1);
    end else if (update && found) begin
      ptr <= grant_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ============================================================================
// Module      : apb_master_arbiter
// Description : Shares one APB master port among NUM_REQ requesters.
//               Round-robin grant, SETUP/ACCESS sequencing, one-hot PSEL
//               decode, ACCESS-phase watchdog, one-cycle response pulse.
// Ports       : clk, reset_n            clock, synchronous active-low reset
//               req_valid/req_ready     per-requester handshake (ready is
//                                       combinational, one-hot, IDLE only)
//               req_write/addr/slv/prot/wdata/strb  packed request fields
//               rsp_valid/rdata/err     one-hot completion to the owner
//               apb_addr..apb_strb      registered APB master outputs
//               apb_ready/rdata/slv_err APB slave responses
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_master_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 3,
  parameter int SEL_WIDTH   = 2,
  parameter int WRITE_WIDTH = 32,
  parameter int READ_WIDTH  = WRITE_WIDTH,
  parameter int TIMEOUT     = 16,
  localparam int STRB_WIDTH = strb_width(WRITE_WIDTH),
  localparam int SIDX_W     = sidx_width(SEL_WIDTH),
  localparam int AW         = ADDR_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*AW-1:0]          req_addr,
  input  logic [NUM_REQ*SIDX_W-1:0]      req_slv,
  input  logic [NUM_REQ*3-1:0]           req_prot,
  input  logic [NUM_REQ*WRITE_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]  req_strb,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [READ_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [ADDR_WIDTH:0]            apb_addr,
  output logic [2:0]                     apb_prot,
  output logic [SEL_WIDTH-1:0]           apb_sel,
  output logic                           apb_enable,
  output logic                           apb_write,
  output logic [WRITE_WIDTH-1:0]         apb_wdata,
  output logic [STRB_WIDTH-1:0]          apb_strb,
  input  logic                           apb_ready,
  input  logic [READ_WIDTH-1:0]          apb_rdata,
  input  logic                           apb_slv_err
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e                  state;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      owner;
  logic [WD_W-1:0]         wd_cnt;
  logic                    in_idle;

  // Fields of the current grant winner, muxed by the one-hot grant.
  logic                    sel_write;
  logic [AW-1:0]           sel_addr;
  logic [SIDX_W-1:0]       sel_slv;
  logic [2:0]              sel_prot;
  logic [WRITE_WIDTH-1:0]  sel_wdata;
  logic [STRB_WIDTH-1:0]   sel_strb;
  logic                    bad_slv;
  logic [SEL_WIDTH-1:0]    sel_dec;

  assign in_idle   = (state == IDLE) && reset_n;
  assign req_ready = in_idle ? grant : '0;

  apb_rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .update  (in_idle),
    .grant   (grant)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_slv   = '0;
    sel_prot  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_slv   = req_slv[i*SIDX_W +: SIDX_W];
        sel_prot  = req_prot[i*3 +: 3];
        sel_wdata = req_wdata[i*WRITE_WIDTH +: WRITE_WIDTH];
        sel_strb  = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  // An index that does not name an existing slave never reaches the bus.
  assign bad_slv = (int'(sel_slv) >= SEL_WIDTH);
  assign sel_dec = bad_slv ? '0 : (SEL_WIDTH'(1) << sel_slv);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= '0;
      wd_cnt     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      apb_addr   <= '0;
      apb_prot   <= '0;
      apb_sel    <= '0;
      apb_enable <= 1'b0;
      apb_write  <= 1'b0;
      apb_wdata  <= '0;
      apb_strb   <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner <= grant;
            if (bad_slv) begin
              state     <= RESP;
              rsp_valid <= grant;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state      <= SETUP;
              apb_sel    <= sel_dec;
              apb_enable <= 1'b0;
              apb_addr   <= sel_addr;
              apb_prot   <= sel_prot;
              apb_write  <= sel_write;
              apb_wdata  <= sel_wdata;
              apb_strb   <= sel_strb;
            end
          end
        end

        SETUP: begin
          state      <= ACCESS;
          apb_enable <= 1'b1;
          wd_cnt     <= '0;
        end

        ACCESS: begin
          if (apb_ready) begin
            state      <= RESP;
            rsp_valid  <= owner;
            rsp_rdata  <= apb_write ? '0 : apb_rdata;
            rsp_err    <= apb_slv_err;
            apb_sel    <= '0;
            apb_enable <= 1'b0;
          end else if ((TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1))) begin
            // Last permitted ACCESS cycle passed without ready.
            state      <= RESP;
            rsp_valid  <= owner;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b1;
            apb_sel    <= '0;
            apb_enable <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        RESP: begin
          state     <= IDLE;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
